counter_input_conditioner: RTL and testbench

- Input-conditioning stage placed directly upstream of the 8-bit programmable counter.
- Turns raw, asynchronous, bouncy pin-level controls into clean single-cycle strobes the counter consumes:
  - ENABLE-style count pulses, at a programmable prescaled rate or by single-step;
  - a LOAD strobe with synchronized load data.
- Keeps the counter itself purely synchronous and glitch-free.

---
 rtl/counter_input_conditioner.sv | 151 +++++++++++++++
 tb/tb_counter_input_conditioner.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_input_conditioner.sv
// Input conditioner for the 8-bit programmable counter: synchronizes and debounces the raw
// enable/load/step controls and turns them into clean single-cycle count and load strobes.
module counter_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DIV_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_raw,
  input  logic             load_raw,
  input  logic             step_raw,
  input  logic [7:0]       data_raw,
  input  logic [DIV_W-1:0] div_val,
  output logic             count_en,
  output logic             load_pulse,
  output logic [7:0]       load_data,
  output logic             running
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int EN = 0;
  localparam int LD = 1;
  localparam int ST = 2;

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       raw_bits;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       deb_lvl;
  logic [2:0]       flip;
  logic [7:0]       db_cnt [3];
  logic [7:0]       data_s1;
  logic [7:0]       data_s2;
  logic             primed;
  logic [1:0]       armed;
  logic [0:0]       state;
  logic [DIV_W-1:0] pc;
  logic             en_rise;
  logic             en_fall;
  logic             ld_evt;
  logic             st_evt;

  assign raw_bits = {step_raw, load_raw, enable_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      sync1   <= raw_bits;
      sync2   <= sync1;
      data_s1 <= data_raw;
      data_s2 <= data_s1;
    end
  end

  // A level flips on the cycle its disagreement count would reach DEBOUNCE_CYCLES.
  always_comb begin
    flip = '0;
    for (int i = 0; i < 3; i++) begin
      flip[i] = (sync2[i] != deb_lvl[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_lvl <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (flip[i]) begin
          deb_lvl[i] <= ~deb_lvl[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Load and step only fire after their raw pin has been seen low since reset, so a
  // button already held at release never produces a strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed <= 1'b0;
      armed  <= '0;
    end else begin
      primed <= 1'b1;
      armed  <= armed | ({2{primed}} & ~sync1[ST:LD]);
    end
  end

  assign en_rise = flip[EN] & ~deb_lvl[EN];
  assign en_fall = flip[EN] &  deb_lvl[EN];
  assign ld_evt  = flip[LD] & ~deb_lvl[LD] & armed[0];
  assign st_evt  = flip[ST] & ~deb_lvl[ST] & armed[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_pulse <= 1'b0;
      load_data  <= 8'h00;
    end else begin
      load_pulse <= ld_evt;
      if (ld_evt) begin
        load_data <= data_s2;
      end
    end
  end

  // Prescaler FSM; a load strobe always wins the cycle and restarts the period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      count_en <= 1'b0;
    end else if (state == IDLE) begin
      pc       <= '0;
      count_en <= st_evt & ~ld_evt & ~en_rise;
      if (en_rise) begin
        state <= RUN;
      end
    end else begin
      if (en_fall) begin
        state    <= IDLE;
        pc       <= '0;
        count_en <= 1'b0;
      end else if (ld_evt) begin
        pc       <= '0;
        count_en <= 1'b0;
      end else if (pc >= div_val) begin
        pc       <= '0;
        count_en <= 1'b1;
      end else begin
        pc       <= pc + DIV_W'(1);
        count_en <= 1'b0;
      end
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_counter_input_conditioner.sv
// Self-checking bench for counter_input_conditioner: directed scenarios plus random bouncy
// inputs, all compared against a window-based behavioural model of the conditioner.
module tb_counter_input_conditioner;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable_raw = 1'b0;
  logic       load_raw = 1'b0;
  logic       step_raw = 1'b0;
  logic [7:0] data_raw = 8'h00;
  logic [7:0] div_val = 8'h00;
  logic       count_en;
  logic       load_pulse;
  logic [7:0] load_data;
  logic       running;

  int checks = 0;
  int errors = 0;

  counter_input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .DIV_W          (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable_raw(enable_raw),
    .load_raw  (load_raw),
    .step_raw  (step_raw),
    .data_raw  (data_raw),
    .div_val   (div_val),
    .count_en  (count_en),
    .load_pulse(load_pulse),
    .load_data (load_data),
    .running   (running)
  );

  always #5 clk = ~clk;

  // Model state: raw sample history (index 0 = newest edge), debounced levels, arming flags.
  bit         hist [3][0:DB+1];
  logic [7:0] dhist [0:2];
  bit         deb_m [3];
  bit         armed_m [3];
  int         edges;
  int         elapsed;
  logic       m_count_en;
  logic       m_load_pulse;
  logic       m_running;
  logic [7:0] m_load_data;

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k <= DB + 1; k++) hist[i][k] = 1'b0;
      deb_m[i]   = 1'b0;
      armed_m[i] = 1'b0;
    end
    for (int k = 0; k < 3; k++) dhist[k] = 8'h00;
    edges        = 0;
    elapsed      = 0;
    m_count_en   = 1'b0;
    m_load_pulse = 1'b0;
    m_running    = 1'b0;
    m_load_data  = 8'h00;
  endtask

  // A level flips once the last DB synchronized samples (two edges old) all disagree with it.
  task automatic modelEdge();
    bit smp [3];
    bit rise [3];
    bit fall [3];
    bit all_diff;
    bit ldp;
    bit stp;
    smp[0] = enable_raw;
    smp[1] = load_raw;
    smp[2] = step_raw;
    for (int i = 0; i < 3; i++) begin
      for (int k = DB + 1; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = smp[i];
    end
    dhist[2] = dhist[1];
    dhist[1] = dhist[0];
    dhist[0] = data_raw;
    if (edges < 1000) edges++;
    for (int i = 1; i < 3; i++) begin
      if (edges >= 3 && !hist[i][2]) armed_m[i] = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      all_diff = 1'b1;
      for (int j = 2; j <= DB + 1; j++) begin
        if (hist[i][j] == deb_m[i]) all_diff = 1'b0;
      end
      rise[i] = all_diff && !deb_m[i];
      fall[i] = all_diff && deb_m[i];
      if (all_diff) deb_m[i] = !deb_m[i];
    end
    ldp = rise[1] && armed_m[1];
    stp = rise[2] && armed_m[2];
    m_load_pulse = ldp;
    if (ldp) m_load_data = dhist[2];
    if (!m_running) begin
      elapsed    = 0;
      m_count_en = stp && !ldp && !rise[0];
      if (rise[0]) m_running = 1'b1;
    end else if (fall[0]) begin
      m_running  = 1'b0;
      elapsed    = 0;
      m_count_en = 1'b0;
    end else if (ldp) begin
      elapsed    = 0;
      m_count_en = 1'b0;
    end else if (elapsed >= int'(div_val)) begin
      elapsed    = 0;
      m_count_en = 1'b1;
    end else begin
      elapsed++;
      m_count_en = 1'b0;
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkOutput();
    checkValue("count_en", count_en, m_count_en);
    checkValue("load_pulse", load_pulse, m_load_pulse);
    checkValue("load_data", load_data, m_load_data);
    checkValue("running", running, m_running);
  endtask

  task automatic applyStimulus(input bit en, input bit ld, input bit st,
                               input logic [7:0] d, input logic [7:0] dv);
    enable_raw = en;
    load_raw   = ld;
    step_raw   = st;
    data_raw   = d;
    div_val    = dv;
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput();
  endtask

  // Reset is asserted mid-cycle so the asynchronous clear is observed before any edge.
  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("rst_count_en", count_en, 1'b0);
    checkValue("rst_load_pulse", load_pulse, 1'b0);
    checkValue("rst_load_data", load_data, 8'h00);
    checkValue("rst_running", running, 1'b0);
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int         first_run;
  int         n_pulse;
  int         pulse_at;
  bit         found;
  logic [7:0] got_data;
  bit         lvl [3];
  bit         glitch;

  initial begin
    $display("[TB] counter_input_conditioner bench start");
    modelReset();

    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'd3);
    doReset();
    first_run = 0;
    n_pulse   = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (running && first_run == 0) first_run = i;
      if (load_pulse) n_pulse++;
    end
    checkValue("running_latency", first_run, 6);
    checkValue("no_load_at_release", n_pulse, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C, 8'd3);
    repeat (10) tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h3C, 8'd3);
    n_pulse = 0;
    repeat (10) begin
      tick();
      if (load_pulse) n_pulse++;
    end
    checkValue("load_after_repress", n_pulse, 1);

    applyStimulus(1'b0, 1'b0, 1'b0, 8'hA5, 8'd3);
    repeat (12) tick();
    n_pulse  = 0;
    pulse_at = 0;
    got_data = 8'h00;
    for (int i = 1; i <= 14; i++) begin
      applyStimulus(1'b0, (i == 2) ? 1'b0 : 1'b1, 1'b0, 8'hA5, 8'd3);
      tick();
      if (load_pulse) begin
        n_pulse++;
        pulse_at = i;
        got_data = load_data;
      end
    end
    checkValue("bounce_pulse_count", n_pulse, 1);
    checkValue("bounce_pulse_edge", pulse_at, 8);
    checkValue("bounce_load_data", got_data, 8'hA5);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hA5, 8'd3);
    repeat (10) tick();

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'd3);
    repeat (20) tick();
    n_pulse = 0;
    repeat (12) begin
      tick();
      if (count_en) n_pulse++;
    end
    checkValue("div3_rate", n_pulse, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'd0);
    repeat (3) tick();
    n_pulse = 0;
    repeat (10) begin
      tick();
      if (count_en) n_pulse++;
    end
    checkValue("div0_continuous", n_pulse, 10);

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'd9);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (count_en) found = 1'b1;
    end
    checkValue("div9_tick_seen", found, 1'b1);
    repeat (7) tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'd2);
    for (int k = 1; k <= 7; k++) begin
      tick();
      checkValue("div_lowered", count_en, (k % 3 == 1) ? 1'b1 : 1'b0);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'd4);
    repeat (10) tick();
    n_pulse = 0;
    repeat (3) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'd4);
      repeat (10) begin
        tick();
        if (count_en) n_pulse++;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'd4);
      repeat (10) begin
        tick();
        if (count_en) n_pulse++;
      end
    end
    checkValue("idle_step_count", n_pulse, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'd4);
    repeat (10) tick();
    repeat (3) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 8'd4);
      repeat (10) tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'd4);
      repeat (10) tick();
    end

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (count_en) found = 1'b1;
    end
    checkValue("div4_tick_seen", found, 1'b1);
    repeat (4) tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A, 8'd4);
    repeat (5) tick();
    tick();
    checkValue("collide_load_pulse", load_pulse, 1'b1);
    checkValue("collide_count_en", count_en, 1'b0);
    checkValue("collide_load_data", load_data, 8'h5A);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkValue("tick_after_load", count_en, (k == 5) ? 1'b1 : 1'b0);
    end
    repeat (2) tick();
    doReset();
    repeat (12) tick();

    for (int i = 0; i < 3; i++) lvl[i] = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      for (int j = 0; j < 3; j++) begin
        if ($urandom_range(0, 19) == 0) lvl[j] = !lvl[j];
      end
      glitch = ($urandom_range(0, 29) == 0);
      enable_raw = lvl[0] ^ (glitch && $urandom_range(0, 2) == 0);
      load_raw   = lvl[1] ^ (glitch && $urandom_range(0, 2) == 1);
      step_raw   = lvl[2] ^ (glitch && $urandom_range(0, 2) == 2);
      if (!lvl[1]) data_raw = 8'($urandom);
      if ($urandom_range(0, 63) == 0) div_val = 8'($urandom_range(0, 6));
      if (i == 800) doReset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
